ula_arbitro: RTL and testbench
==============================

ULA_ARBITRO -- requirements
Module: ula_arbitro

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, meaning cycles operands are held on the ULA before capture (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req_valid[i], i=0,1  input  1  requester i presents an operation.
REQ-005 SHALL have ports req_ready[i]  output  1  requester i operation accepted this cycle when also valid.
REQ-006 SHALL have ports req_sel[i]  input  4  ULA opcode (0000 soma .. 1111 A==B).
REQ-007 SHALL have ports req_a[i]  input  2  operand A.
REQ-008 SHALL have ports req_b[i]  input  2  operand B; bit 1 used only by opcodes 1110/1111.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-011 SHALL have port rsp_data  output  3  captured ULA Saida.
REQ-012 SHALL have port rsp_id  output  1  index of requester owning rsp_data.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port op_count  output  8  completed responses, wraps 255 -> 0.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 In IDLE, grant SHALL go to the single valid requester; if both are valid, to the requester not served last (last pointer reset value 1, so requester 0 wins first tie).
REQ-017 req_ready[i] SHALL be combinational: high only in IDLE for the granted requester; never both high; always 0 outside IDLE.
REQ-018 On handshake (valid & ready) the block SHALL register sel, a, b, id, load exec counter with EXEC_CYCLES-1, and enter EXEC.
REQ-019 In EXEC the ULA SHALL be driven solely from the operand registers; requester inputs SHALL be ignored.
REQ-020 In EXEC with counter 0, the edge SHALL capture Saida into rsp_data, id into rsp_id, and enter RESP; otherwise counter decrements.
REQ-021 In RESP rsp_valid SHALL be 1 with rsp_data/rsp_id stable until rsp_ready is sampled high; that edge SHALL return to IDLE, update last pointer to rsp_id, increment op_count.
REQ-022 Latency: handshake edge T -> rsp_valid high from edge T+EXEC_CYCLES; minimum issue interval EXEC_CYCLES+2 cycles with rsp_ready held high.
REQ-023 rsp_ready high outside RESP SHALL have no effect; request arriving in EXEC/RESP SHALL wait (not dropped, not accepted).
REQ-024 Requester deasserting valid before handshake SHALL not be granted on later cycles unless reasserted.
REQ-025 op_count SHALL wrap from 8'hFF to 8'h00 without any flag.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, rsp_valid 0, rsp_data 000, rsp_id 0, busy 0, op_count 0, operand registers 0, exec counter 0, last pointer 1.
REQ-027 Reset asserted mid-EXEC or mid-RESP SHALL discard the pending operation; no response is produced after release.
REQ-028 First handshake SHALL be possible in the first cycle after rst_n deasserts.

Structure
REQ-029 Package ula_pkg SHALL hold opcode constants (OP_SOMA=0000 .. OP_IGUAL=1111), state encoding, widths SEL_W=4, OP_W=2, RES_W=3.
REQ-030 The block SHALL instantiate exactly one existing ula sub-module (Sel, A, B, Saida) as the shared datapath; no second ULA.

Verification
REQ-031 Single op: req0 sel 0000 a 01 b 01, rsp_ready 1, EXEC_CYCLES 1 -> rsp_data 010, rsp_id 0, rsp_valid one cycle after acceptance edge, op_count 1.
REQ-032 Tie: req0 sel 0010 a 11 b 01 and req1 sel 1110 a 10 b 01 both valid from reset -> responses 011 id 0 then 001 id 1; next tie goes to req0.
REQ-033 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id constant; req_ready both 0; completes on first rsp_ready high.
REQ-034 Reset mid-op: assert rst_n low during EXEC (EXEC_CYCLES 4) -> immediate rsp_valid 0, busy 0, op_count 0; no response after release.
REQ-035 Wrap: 256 back-to-back sel 1111 a 11 b 11 -> each rsp_data 001; op_count reads 0 after 256th response.
REQ-036 Latency: EXEC_CYCLES 3, req1 sel 0100 a 01 -> rsp_valid exactly 3 edges after handshake, rsp_data 010, id 1.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared constants for the ULA and its two-requester arbiter.
//   SEL_W/OP_W/RES_W  opcode, operand and result widths
//   OP_*              ULA opcodes (OP_SOMA=0000 .. OP_IGUAL=1111)
//   state_t           arbiter FSM encoding
package ula_pkg;

    localparam int unsigned SEL_W = 4;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned RES_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [SEL_W-1:0] OP_SOMA    = 4'b0000;
    localparam logic [SEL_W-1:0] OP_SUB     = 4'b0001;
    localparam logic [SEL_W-1:0] OP_OU      = 4'b0010;
    localparam logic [SEL_W-1:0] OP_E       = 4'b0011;
    localparam logic [SEL_W-1:0] OP_SHL     = 4'b0100;
    localparam logic [SEL_W-1:0] OP_SHR     = 4'b0101;
    localparam logic [SEL_W-1:0] OP_XOU     = 4'b0110;
    localparam logic [SEL_W-1:0] OP_NAO     = 4'b0111;
    localparam logic [SEL_W-1:0] OP_PASSA_A = 4'b1000;
    localparam logic [SEL_W-1:0] OP_PASSA_B = 4'b1001;
    localparam logic [SEL_W-1:0] OP_INC     = 4'b1010;
    localparam logic [SEL_W-1:0] OP_DEC     = 4'b1011;
    localparam logic [SEL_W-1:0] OP_ZERO    = 4'b1100;
    localparam logic [SEL_W-1:0] OP_CONCAT  = 4'b1101;
    localparam logic [SEL_W-1:0] OP_MAIOR   = 4'b1110;
    localparam logic [SEL_W-1:0] OP_IGUAL   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/ula.sv
// ula: combinational 2-bit ULA with 3-bit result.
//   Sel   opcode (see ula_pkg OP_*)
//   A     operand A
//   B     operand B; only B[0] participates except for OP_MAIOR/OP_IGUAL
//   Saida result, zero-extended to RES_W
module ula
    import ula_pkg::*;
(
    input  logic [SEL_W-1:0] Sel,
    input  logic [OP_W-1:0]  A,
    input  logic [OP_W-1:0]  B,
    output logic [RES_W-1:0] Saida
);

    logic [RES_W-1:0] a3;
    logic [RES_W-1:0] b0;

    assign a3 = {1'b0, A};
    assign b0 = {2'b00, B[0]};

    always_comb begin
        Saida = '0;
        case (Sel)
            OP_SOMA:    Saida = a3 + b0;
            OP_SUB:     Saida = a3 - b0;
            OP_OU:      Saida = a3 | b0;
            OP_E:       Saida = a3 & b0;
            OP_SHL:     Saida = {A, 1'b0};
            OP_SHR:     Saida = {2'b00, A[1]};
            OP_XOU:     Saida = a3 ^ b0;
            OP_NAO:     Saida = {1'b0, ~A};
            OP_PASSA_A: Saida = a3;
            OP_PASSA_B: Saida = b0;
            OP_INC:     Saida = a3 + 3'd1;
            OP_DEC:     Saida = a3 - 3'd1;
            OP_ZERO:    Saida = '0;
            OP_CONCAT:  Saida = {B[0], A};
            OP_MAIOR:   Saida = {2'b00, A > B};
            OP_IGUAL:   Saida = {2'b00, A == B};
            default:    Saida = '0;
        endcase
    end

endmodule

// File: rtl/ula_arbitro.sv
// ula_arbitro: round-robin arbiter sharing one ULA between two requesters.
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready[i]  per-requester handshake (ready is combinational)
//   req_sel/req_a/req_b[i]  per-requester opcode and operands
//   rsp_valid/rsp_ready     result handshake
//   rsp_data, rsp_id        captured ULA result and owning requester
//   busy                    high whenever not IDLE
//   op_count                completed responses, wraps silently
// Operands are held in registers for EXEC_CYCLES cycles before the result is
// captured, so the ULA never sees requester inputs while an op is in flight.
module ula_arbitro
    import ula_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0][SEL_W-1:0]      req_sel,
    input  logic [1:0][OP_W-1:0]       req_a,
    input  logic [1:0][OP_W-1:0]       req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [RES_W-1:0]           rsp_data,
    output logic                       rsp_id,
    output logic                       busy,
    output logic [7:0]                 op_count
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [OP_W-1:0]    a_q, b_q;
    logic               id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q;
    logic [RES_W-1:0]   rsp_data_q;
    logic               rsp_id_q;
    logic [7:0]         op_count_q;

    logic               grant_id;
    logic               handshake;
    logic [RES_W-1:0]   saida;

    // On a tie the requester not served last wins; otherwise the lone one.
    assign grant_id  = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    assign handshake = |(req_valid & req_ready);

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready[grant_id] = 1'b1;
                    state_d             = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (handshake) begin
                        sel_q <= req_sel[grant_id];
                        a_q   <= req_a[grant_id];
                        b_q   <= req_b[grant_id];
                        id_q  <= grant_id;
                        cnt_q <= CNT_LOAD;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        rsp_data_q <= saida;
                        rsp_id_q   <= id_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        last_q     <= rsp_id_q;
                        op_count_q <= op_count_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    ula u_ula (
        .Sel   (sel_q),
        .A     (a_q),
        .B     (b_q),
        .Saida (saida)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// tb_ula_arbitro: directed scoreboard bench. Three DUT copies (EXEC_CYCLES
// 1, 3, 4) share every input; each section checks only the copy it targets.
module tb_ula_arbitro;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0][3:0]  req_sel;
    logic [1:0][1:0]  req_a;
    logic [1:0][1:0]  req_b;
    logic             rsp_ready;

    logic [1:0]       rr  [3];
    logic             rv  [3];
    logic [2:0]       rd  [3];
    logic             rid [3];
    logic             bz  [3];
    logic [7:0]       oc  [3];

    int errors = 0;
    int checks = 0;
    logic [3:0] sb [$];   // {id, data}

    ula_arbitro #(.EXEC_CYCLES(1)) dut_e1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[0]),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b), .rsp_valid(rv[0]),
        .rsp_ready(rsp_ready), .rsp_data(rd[0]), .rsp_id(rid[0]), .busy(bz[0]),
        .op_count(oc[0])
    );
    ula_arbitro #(.EXEC_CYCLES(3)) dut_e3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[1]),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b), .rsp_valid(rv[1]),
        .rsp_ready(rsp_ready), .rsp_data(rd[1]), .rsp_id(rid[1]), .busy(bz[1]),
        .op_count(oc[1])
    );
    ula_arbitro #(.EXEC_CYCLES(4)) dut_e4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr[2]),
        .req_sel(req_sel), .req_a(req_a), .req_b(req_b), .rsp_valid(rv[2]),
        .rsp_ready(rsp_ready), .rsp_data(rd[2]), .rsp_id(rid[2]), .busy(bz[2]),
        .op_count(oc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ULA written as integer arithmetic on the operand values.
    function automatic logic [2:0] model(input logic [3:0] s, input logic [1:0] a,
                                         input logic [1:0] b);
        int ai;
        int bi;
        int r;
        ai = int'(a);
        bi = int'(b[0]);
        case (s)
            4'd0:    r = ai + bi;
            4'd1:    r = ai - bi;
            4'd2:    r = ai | bi;
            4'd3:    r = ai & bi;
            4'd4:    r = ai * 2;
            4'd5:    r = ai / 2;
            4'd6:    r = ai ^ bi;
            4'd7:    r = 3 - ai;
            4'd8:    r = ai;
            4'd9:    r = bi;
            4'd10:   r = ai + 1;
            4'd11:   r = ai - 1;
            4'd12:   r = 0;
            4'd13:   r = bi * 4 + ai;
            4'd14:   r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        return r[2:0];
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present an op from requester id, wait for dut k to grant it, push the
    // expected result, and drop valid right after the handshake edge.
    task automatic issue(input int k, input int id, input logic [3:0] s,
                         input logic [1:0] a, input logic [1:0] b);
        int n;
        n = 0;
        req_sel[id]   = s;
        req_a[id]     = a;
        req_b[id]     = b;
        req_valid[id] = 1'b1;
        #1;
        while (rr[k][id] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(rr[k][id]), 32'd1);
        sb.push_back({id[0], model(s, a, b)});
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid on dut k; w = extra negedges waited.
    task automatic collect(input int k, input string tag, output int w);
        logic [3:0] e;
        w = 0;
        @(negedge clk);
        while (rv[k] !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, 32'(rv[k]), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : 4'hx;
        chk({tag, "_data"}, 32'(rd[k]), 32'(e[2:0]));
        chk({tag, "_id"}, 32'(rid[k]), 32'(e[3]));
    endtask

    initial begin
        int  w;
        bit  seen;
        rst_n     = 1'b0;
        req_valid = '0;
        req_sel   = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state, then single op accepted on the first edge after release
        do_reset();
        chk("rst_valid", 32'(rv[0]), 32'd0);
        chk("rst_data", 32'(rd[0]), 32'd0);
        chk("rst_id", 32'(rid[0]), 32'd0);
        chk("rst_busy", 32'(bz[0]), 32'd0);
        chk("rst_count", 32'(oc[0]), 32'd0);
        rsp_ready = 1'b1;
        issue(0, 0, 4'b0000, 2'b01, 2'b01);
        chk("single_busy", 32'(bz[0]), 32'd1);
        collect(0, "single", w);
        chk("single_latency", 32'(w), 32'd1);
        @(negedge clk);
        chk("single_count", 32'(oc[0]), 32'd1);
        chk("single_idle", 32'(bz[0]), 32'd0);

        // Tie from reset: req0 first, then req1, next tie back to req0
        rst_n      = 1'b0;
        sb.delete();
        req_sel[0] = 4'b0010; req_a[0] = 2'b11; req_b[0] = 2'b01;
        req_sel[1] = 4'b1110; req_a[1] = 2'b10; req_b[1] = 2'b01;
        req_valid  = 2'b11;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tie_first_ready", 32'(rr[0]), 32'd1);
        sb.push_back({1'b0, model(4'b0010, 2'b11, 2'b01)});
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        collect(0, "tie0", w);
        @(negedge clk);
        chk("tie_second_ready", 32'(rr[0]), 32'd2);
        sb.push_back({1'b1, model(4'b1110, 2'b10, 2'b01)});
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        collect(0, "tie1", w);
        req_valid = 2'b11;
        @(negedge clk);
        chk("tie_third_ready", 32'(rr[0]), 32'd1);
        sb.push_back({1'b0, model(4'b0010, 2'b11, 2'b01)});
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        collect(0, "tie2", w);

        // Backpressure: response must hold while rsp_ready is low
        do_reset();
        issue(0, 1, 4'b0001, 2'b10, 2'b01);
        collect(0, "bp", w);
        req_valid = 2'b11;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(rv[0]), 32'd1);
            chk("bp_hold_data", 32'(rd[0]), 32'd1);
            chk("bp_hold_id", 32'(rid[0]), 32'd1);
            chk("bp_hold_ready", 32'(rr[0]), 32'd0);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(rv[0]), 32'd0);
        chk("bp_release_count", 32'(oc[0]), 32'd1);

        // A request withdrawn before it could be granted is never accepted
        do_reset();
        rsp_ready = 1'b1;
        issue(0, 0, 4'b1010, 2'b01, 2'b00);
        req_sel[1]   = 4'b0000;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        collect(0, "drop", w);
        repeat (3) begin
            @(negedge clk);
            chk("drop_not_granted", 32'(bz[0]), 32'd0);
        end

        // Latency with EXEC_CYCLES=3
        do_reset();
        rsp_ready = 1'b1;
        issue(1, 1, 4'b0100, 2'b01, 2'b00);
        collect(1, "lat", w);
        chk("lat_edges", 32'(w), 32'd3);

        // Reset in the middle of EXEC with EXEC_CYCLES=4
        do_reset();
        rsp_ready = 1'b1;
        issue(2, 0, 4'b0000, 2'b01, 2'b01);
        collect(2, "pre_rst", w);
        issue(2, 0, 4'b0011, 2'b11, 2'b01);
        @(posedge clk);
        #1;
        chk("midrst_busy_before", 32'(bz[2]), 32'd1);
        chk("midrst_count_before", 32'(oc[2]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rv[2]), 32'd0);
        chk("midrst_busy", 32'(bz[2]), 32'd0);
        chk("midrst_count", 32'(oc[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rv[2] === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_rsp", 32'(seen), 32'd0);

        // op_count wraps after 256 responses
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            issue(0, 0, 4'b1111, 2'b11, 2'b11);
            collect(0, "wrap", w);
            if (i == 255) chk("wrap_pre_count", 32'(oc[0]), 32'd255);
        end
        @(negedge clk);
        chk("wrap_count", 32'(oc[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
